// File: rtl/char_grid_engine.sv
// Character/colour grid with hardware CLEAR and one-line SCROLL (ring-buffer row offset).
// Optional blinking cursor overlay is enabled by defining CHAR_GRID_CURSOR_EN.
module char_grid_engine #(
    parameter int unsigned          WIDTH        = 80,
    parameter int unsigned          HEIGHT       = 45,
    parameter int unsigned          CHAR_W       = 8,
    parameter int unsigned          COLOR_W      = 12,
    parameter int unsigned          X_W          = 7,
    parameter int unsigned          Y_W          = 6,
`ifdef CHAR_GRID_CURSOR_EN
    parameter int unsigned          BLINK_CYCLES = 25_000_000,
`endif
    parameter logic [CHAR_W-1:0]    BLANK_CHAR   = 8'h20,
    parameter logic [COLOR_W-1:0]   BLANK_COLOR  = 12'h000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               w_valid_i,
    output logic               w_ready_o,
    input  logic [X_W-1:0]     w_pos_x_i,
    input  logic [Y_W-1:0]     w_pos_y_i,
    input  logic [CHAR_W-1:0]  w_char_i,
    input  logic [COLOR_W-1:0] w_color_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_op_i,
    output logic               busy_o,
    input  logic [X_W-1:0]     r_pos_x_i,
    input  logic [Y_W-1:0]     r_pos_y_i,
`ifdef CHAR_GRID_CURSOR_EN
    input  logic [X_W-1:0]     cur_x_i,
    input  logic [Y_W-1:0]     cur_y_i,
    output logic               r_cursor_o,
`endif
    output logic [CHAR_W-1:0]  r_char_o,
    output logic [COLOR_W-1:0] r_color_o
);

    localparam int unsigned Cells = WIDTH * HEIGHT;
    localparam int unsigned AddrW = $clog2(Cells);
    localparam int unsigned DataW = CHAR_W + COLOR_W;

    typedef enum logic [1:0] {StIdle, StClear, StScroll} state_e;

    // Both operands are below HEIGHT, so one conditional subtract replaces the modulo.
    function automatic logic [Y_W-1:0] phys_row(input logic [Y_W-1:0] y,
                                                input logic [Y_W-1:0] top);
        logic [Y_W:0] sum;
        sum = {1'b0, y} + {1'b0, top};
        if (32'(sum) >= HEIGHT) begin
            sum = sum - (Y_W+1)'(HEIGHT);
        end
        return sum[Y_W-1:0];
    endfunction

    function automatic logic [AddrW-1:0] cell_addr(input logic [Y_W-1:0] row,
                                                   input logic [X_W-1:0] x);
        return AddrW'(row) * AddrW'(WIDTH) + AddrW'(x);
    endfunction

    state_e           state_q, state_d;
    logic [Y_W-1:0]   top_row_q, top_row_d;
    logic [AddrW-1:0] fill_addr_q, fill_addr_d;
    logic [AddrW-1:0] fill_last_q, fill_last_d;
    logic             busy_q, busy_d;

    logic             ram_we;
    logic [AddrW-1:0] ram_waddr;
    logic [DataW-1:0] ram_wdata;
    logic [AddrW-1:0] rd_addr;
    logic [DataW-1:0] rd_data_q;
    logic             rd_oor_q;
    logic             rd_live_q;

    logic [DataW-1:0] mem [Cells];

    logic             w_in_range;
    logic             r_in_range;
    logic [AddrW-1:0] w_addr;

    assign w_in_range = (32'(w_pos_x_i) < WIDTH) && (32'(w_pos_y_i) < HEIGHT);
    assign r_in_range = (32'(r_pos_x_i) < WIDTH) && (32'(r_pos_y_i) < HEIGHT);
    assign w_addr     = cell_addr(phys_row(w_pos_y_i, top_row_q), w_pos_x_i);
    assign rd_addr    = r_in_range ? cell_addr(phys_row(r_pos_y_i, top_row_q), r_pos_x_i) : '0;

    assign w_ready_o   = (state_q == StIdle);
    assign cmd_ready_o = (state_q == StIdle);
    assign busy_o      = busy_q;

    always_comb begin
        state_d     = state_q;
        top_row_d   = top_row_q;
        fill_addr_d = fill_addr_q;
        fill_last_d = fill_last_q;
        ram_we      = 1'b0;
        ram_waddr   = fill_addr_q;
        ram_wdata   = {BLANK_CHAR, BLANK_COLOR};

        unique case (state_q)
            StIdle: begin
                // The write commits on the acceptance edge, ahead of any command.
                if (w_valid_i && w_in_range) begin
                    ram_we    = 1'b1;
                    ram_waddr = w_addr;
                    ram_wdata = {w_char_i, w_color_i};
                end
                if (cmd_valid_i) begin
                    if (!cmd_op_i) begin
                        state_d     = StClear;
                        top_row_d   = '0;
                        fill_addr_d = '0;
                        fill_last_d = AddrW'(Cells - 1);
                    end else begin
                        state_d     = StScroll;
                        top_row_d   = (32'(top_row_q) == HEIGHT - 1) ? '0 : top_row_q + 1'b1;
                        fill_addr_d = cell_addr(top_row_q, '0);
                        fill_last_d = cell_addr(top_row_q, X_W'(WIDTH - 1));
                    end
                end
            end
            StClear, StScroll: begin
                ram_we = 1'b1;
                if (fill_addr_q == fill_last_q) begin
                    state_d = StIdle;
                end else begin
                    fill_addr_d = fill_addr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            top_row_q   <= '0;
            fill_addr_q <= '0;
            fill_last_q <= '0;
            busy_q      <= 1'b0;
            rd_oor_q    <= 1'b0;
            rd_live_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            top_row_q   <= top_row_d;
            fill_addr_q <= fill_addr_d;
            fill_last_q <= fill_last_d;
            busy_q      <= busy_d;
            rd_oor_q    <= !r_in_range;
            rd_live_q   <= 1'b1;
        end
    end

    // Read-first RAM: a same-cycle write to the read cell returns the old data.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        rd_data_q <= mem[rd_addr];
    end

    always_comb begin
        r_char_o  = '0;
        r_color_o = '0;
        if (rd_live_q) begin
            if (rd_oor_q) begin
                r_char_o  = BLANK_CHAR;
                r_color_o = BLANK_COLOR;
            end else begin
                r_char_o  = rd_data_q[DataW-1:COLOR_W];
                r_color_o = rd_data_q[COLOR_W-1:0];
            end
        end
    end

`ifdef CHAR_GRID_CURSOR_EN
    localparam int unsigned CntW = $clog2(BLINK_CYCLES + 1);

    logic [CntW-1:0] blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic            cursor_q, cursor_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == CntW'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
        cursor_d = (r_pos_x_i == cur_x_i) && (r_pos_y_i == cur_y_i) && phase_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            cursor_q    <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            cursor_q    <= cursor_d;
        end
    end

    assign r_cursor_o = cursor_q;
`endif

endmodule
